// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
//   Deframes 8N1-style UART characters from an already-synchronized, idle-high
//   serial line. The start bit is detected on its falling edge and confirmed at
//   mid-bit. Data bits are sampled once per bit period after that point, LSB
//   first. The stop bit is then checked.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | line idle, waiting for a 1->0 transition
//   START      | confirming the start bit at mid-bit
//   DATA       | sampling DATA_BITS data bits, one per bit period
//   STOP       | sampling the stop bit
//   BREAK_WAIT | stop bit was 0; hold off until the line returns high
//
// Ports
//   clk              system clock, posedge
//   reset            synchronous, active-high
//   serial_in_synced synchronized serial input, idle = 1
//   rx_data          last good received word, bit 0 = first data bit
//   rx_valid         one-cycle strobe, rx_data has just been updated
//   framing_error    one-cycle strobe, stop bit was sampled low
//   rx_busy          high whenever the FSM is not in IDLE
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_in_synced,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 framing_error,
  output logic                 rx_busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 framing_error_q, framing_error_d;
  logic                 rx_busy_q, rx_busy_d;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q + 1'b1;
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    rx_data_d       = rx_data_q;
    rx_valid_d      = 1'b0;
    framing_error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!serial_in_synced) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d = '0;
          // A line back high at mid-bit is a glitch, not a start bit.
          if (serial_in_synced) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          // Right shift: after DATA_BITS samples the first bit lands in bit 0.
          shift_d = {serial_in_synced, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == BW'(DATA_BITS - 1)) state_d = S_STOP;
          else                                  bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          if (serial_in_synced) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            framing_error_d = 1'b1;
            state_d         = S_BREAK_WAIT;
          end
        end
      end
      S_BREAK_WAIT: begin
        // Only leave once the line is high, so a held break cannot look like
        // a new start bit.
        cnt_d = '0;
        if (serial_in_synced) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    rx_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      framing_error_q <= 1'b0;
      rx_busy_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      framing_error_q <= framing_error_d;
      rx_busy_q       <= rx_busy_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign framing_error = framing_error_q;
  assign rx_busy       = rx_busy_q;

endmodule
